count_event_tracker: RTL and testbench

Downstream monitor for the 4-bit up-counter. Samples the counter's `count` output every cycle and classifies each change as a wrap (max to 0), a jump (any non-increment change, e.g. a parallel load), or a compare match. Event records go into a small FIFO and leave over a valid/ready interface. A saturating wrap counter and a sticky overflow flag are also provided for status readout.

---
 rtl/count_event_tracker.sv | 126 ++++++++++++
 tb/tb_count_event_tracker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_tracker.sv
// rtl/count_event_tracker.sv - classifies changes of a monitored counter into WRAP/JUMP/MATCH events queued in a small FIFO
module count_event_tracker #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  count,
   input  logic [WIDTH-1:0]  cmp,
   input  logic              cmp_en,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [1:0]        evt_code,
   output logic [WIDTH-1:0]  evt_value,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              overflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_WRAP  = 2'b01;
   localparam logic [1:0] CODE_JUMP  = 2'b10;
   localparam logic [1:0] CODE_MATCH = 2'b11;

   localparam logic [WIDTH-1:0]  COUNT_MAX = '1;
   localparam logic [WRAP_W-1:0] WRAP_MAX  = '1;

   // Previous sample of the monitored counter
   logic [WIDTH-1:0] prev;
   logic             prev_vld;
   logic [WIDTH-1:0] prev_inc;

   // Event FIFO storage; pointers carry an extra bit to tell full from empty
   logic [1:0]       mem_code  [DEPTH];
   logic [WIDTH-1:0] mem_value [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   logic [1:0]       evt_new;
   logic             fifo_empty;
   logic             fifo_full;
   logic             do_pop;
   logic             do_push;
   logic             do_drop;

   assign prev_inc = prev + WIDTH'(1);

   // Classify the current sample against the previous one, WRAP > JUMP > MATCH
   always_comb begin
      evt_new = CODE_NONE;
      if (prev_vld) begin
         if (prev == COUNT_MAX && count == '0) begin
            evt_new = CODE_WRAP;
         end else if (count != prev && count != prev_inc) begin
            evt_new = CODE_JUMP;
         end else if (cmp_en && count == cmp && count != prev) begin
            evt_new = CODE_MATCH;
         end
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign do_pop  = !fifo_empty && evt_ready;
   assign do_push = (evt_new != CODE_NONE) && (!fifo_full || do_pop);
   assign do_drop = (evt_new != CODE_NONE) && fifo_full && !do_pop;

   // Head is read straight from storage; forced to zero while empty so reset shows zeros
   assign evt_valid = !fifo_empty;
   assign evt_code  = evt_valid ? mem_code[rd_ptr[AW-1:0]]  : '0;
   assign evt_value = evt_valid ? mem_value[rd_ptr[AW-1:0]] : '0;

   // Track the last sample; the first edge after reset only primes it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev     <= '0;
         prev_vld <= 1'b0;
      end else begin
         prev     <= count;
         prev_vld <= 1'b1;
      end
   end

   // Advance FIFO pointers on accepted pushes and pops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Write the event record at the tail; contents are qualified by the pointers
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_code[wr_ptr[AW-1:0]]  <= evt_new;
         mem_value[wr_ptr[AW-1:0]] <= count;
      end
   end

   // Saturating wrap counter (counts dropped wraps too) and sticky drop flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (evt_new == CODE_WRAP && wrap_cnt != WRAP_MAX) begin
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
         end
         if (do_drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_count_event_tracker.sv
// tb/tb_count_event_tracker.sv - self-checking bench for count_event_tracker
module tb_count_event_tracker;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic [3:0] count;
   logic [3:0] cmp;
   logic       cmp_en;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_code;
   logic [3:0] evt_value;
   logic [7:0] wrap_cnt;
   logic       overflow;

   count_event_tracker #(.WIDTH(4), .DEPTH(DEPTH), .WRAP_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .count     (count),
      .cmp       (cmp),
      .cmp_en    (cmp_en),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
      .evt_value (evt_value),
      .wrap_cnt  (wrap_cnt),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;

   typedef struct {
      int code;
      int value;
   } ev_t;

   ev_t m_q[$];
   int  m_prev;
   bit  m_pvld;
   int  m_wrap;
   bit  m_ovf;

   typedef struct {
      int c;
      int cm;
      int ce;
      int rdy;
      int ev;
      int ecode;
      int evalue;
      int eovf;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_prev = 0;
      m_pvld = 0;
      m_wrap = 0;
      m_ovf  = 0;
   endtask

   task automatic model_edge(input int c, input int cm, input int ce, input int rdy);
      int code;
      ev_t e;
      code = 0;
      if (m_pvld) begin
         if (m_prev == 15 && c == 0) code = 1;
         else if (c != m_prev && c != (m_prev + 1) % 16) code = 2;
         else if (ce != 0 && c == cm && c != m_prev) code = 3;
      end
      if (rdy != 0 && m_q.size() > 0) void'(m_q.pop_front());
      if (code != 0) begin
         if (m_q.size() < DEPTH) begin
            e.code  = code;
            e.value = c;
            m_q.push_back(e);
         end else begin
            m_ovf = 1;
         end
      end
      if (code == 1 && m_wrap < 255) m_wrap++;
      m_prev = c;
      m_pvld = 1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " valid"}, int'(evt_valid), int'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk({tag, " code"}, int'(evt_code), m_q[0].code);
         chk({tag, " value"}, int'(evt_value), m_q[0].value);
      end
      chk({tag, " wrap_cnt"}, int'(wrap_cnt), m_wrap);
      chk({tag, " overflow"}, int'(overflow), int'(m_ovf));
   endtask

   // Called at a negedge; leaves the bench at the following negedge
   task automatic step(input int c, input int cm, input int ce, input int rdy);
      count     = 4'(c);
      cmp       = 4'(cm);
      cmp_en    = ce[0];
      evt_ready = rdy[0];
      @(posedge clk);
      model_edge(c, cm, ce, rdy);
      @(negedge clk);
      check_model("model");
   endtask

   task automatic do_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      chk({tag, " evt_valid"}, int'(evt_valid), 0);
      chk({tag, " evt_code"}, int'(evt_code), 0);
      chk({tag, " evt_value"}, int'(evt_value), 0);
      chk({tag, " wrap_cnt"}, int'(wrap_cnt), 0);
      chk({tag, " overflow"}, int'(overflow), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int seen;
      int seen_at;
      int seen_code;
      int seen_value;
      int exp_tail[3];
      int c;
      int r;
      int cm_r;

      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b0;
      count     = '0;
      cmp       = '0;
      cmp_en    = 1'b0;
      evt_ready = 1'b0;
      model_reset();

      tbl[0]  = '{3, 0, 0, 1,  0, 0, 0, 0};
      tbl[1]  = '{4, 0, 0, 1,  0, 0, 0, 0};
      tbl[2]  = '{10, 0, 0, 1, 1, 2, 10, 0};
      tbl[3]  = '{11, 0, 0, 1, 0, 0, 0, 0};
      tbl[4]  = '{3, 5, 1, 1,  1, 2, 3, 0};
      tbl[5]  = '{4, 5, 1, 1,  0, 0, 0, 0};
      tbl[6]  = '{5, 5, 1, 1,  1, 3, 5, 0};
      tbl[7]  = '{5, 5, 1, 1,  0, 0, 0, 0};
      tbl[8]  = '{5, 5, 1, 1,  0, 0, 0, 0};
      tbl[9]  = '{6, 5, 1, 1,  0, 0, 0, 0};
      tbl[10] = '{0, 5, 0, 0,  1, 2, 0, 0};
      tbl[11] = '{8, 5, 0, 0,  1, 2, 0, 0};
      tbl[12] = '{0, 5, 0, 0,  1, 2, 0, 0};
      tbl[13] = '{8, 5, 0, 0,  1, 2, 0, 0};
      tbl[14] = '{0, 5, 0, 0,  1, 2, 0, 1};
      tbl[15] = '{8, 5, 0, 0,  1, 2, 0, 1};
      tbl[16] = '{8, 5, 0, 1,  1, 2, 8, 1};
      tbl[17] = '{8, 5, 0, 1,  1, 2, 0, 1};
      tbl[18] = '{8, 5, 0, 1,  1, 2, 8, 1};
      tbl[19] = '{8, 5, 0, 1,  0, 0, 0, 1};

      @(negedge clk);
      @(negedge clk);
      do_reset("reset");

      // Straight count 0..15,0,1: single WRAP right after the second 0
      seen = 0; seen_at = -1; seen_code = -1; seen_value = -1;
      for (int i = 0; i < 18; i++) begin
         step(i % 16, 0, 0, 1);
         if (evt_valid) begin
            seen++;
            seen_at    = i;
            seen_code  = int'(evt_code);
            seen_value = int'(evt_value);
         end
      end
      chk("count events", seen, 1);
      chk("count event cycle", seen_at, 16);
      chk("count event code", seen_code, 1);
      chk("count event value", seen_value, 0);
      chk("count wrap_cnt", int'(wrap_cnt), 1);

      // Table: load jump, compare match with held value, fill/overflow/drain
      do_reset("reset2");
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].c, tbl[i].cm, tbl[i].ce, tbl[i].rdy);
         chk($sformatf("tbl%0d valid", i), int'(evt_valid), tbl[i].ev);
         if (tbl[i].ev != 0) begin
            chk($sformatf("tbl%0d code", i), int'(evt_code), tbl[i].ecode);
            chk($sformatf("tbl%0d value", i), int'(evt_value), tbl[i].evalue);
         end
         chk($sformatf("tbl%0d overflow", i), int'(overflow), tbl[i].eovf);
      end

      // Full FIFO with a jump coincident with a pop: no drop
      do_reset("reset3");
      step(0, 0, 0, 0);
      step(8, 0, 0, 0);
      step(0, 0, 0, 0);
      step(8, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("full overflow", int'(overflow), 0);
      step(8, 0, 0, 1);
      chk("coinc overflow", int'(overflow), 0);
      chk("coinc valid", int'(evt_valid), 1);
      chk("coinc head", int'(evt_value), 0);
      exp_tail = '{8, 0, 8};
      for (int i = 0; i < 3; i++) begin
         step(8, 0, 0, 1);
         chk($sformatf("drain%0d value", i), int'(evt_value), exp_tail[i]);
         chk($sformatf("drain%0d code", i), int'(evt_code), 2);
      end
      step(8, 0, 0, 1);
      chk("drain empty", int'(evt_valid), 0);
      chk("drain overflow", int'(overflow), 0);

      // 300 wraps: counter saturates, then mid-stream reset flushes
      do_reset("reset4");
      step(15, 0, 0, 1);
      for (int i = 0; i < 300; i++) begin
         step(0, 0, 0, 1);
         step(15, 0, 0, 1);
      end
      chk("wrap saturate", int'(wrap_cnt), 255);
      step(0, 0, 0, 1);
      chk("pre-reset valid", int'(evt_valid), 1);
      do_reset("midreset");
      step(7, 0, 0, 1);
      chk("post-reset first sample", int'(evt_valid), 0);
      step(9, 0, 0, 1);
      chk("post-reset jump", int'(evt_value), 9);

      // Randomized traffic against the reference model
      do_reset("reset5");
      cm_r = int'($urandom_range(0, 15));
      c = 0;
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 5) c = (c + 1) % 16;
         else if (r < 7) c = c;
         else if (r < 8) c = (c == 15) ? 0 : 15;
         else c = int'($urandom_range(0, 15));
         step(c, cm_r, int'($urandom_range(0, 1)),
              ((i % 100) < 40) ? 0 : int'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
